angle_pred_sequencer: RTL

//  Responder for the angle-prediction controller's en1/en2 enable pair. Walks a BLK x BLK

---
 rtl/angle_pred_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/angle_pred_sequencer.sv
`default_nettype none
// ============================================================================
// angle_pred_sequencer : walks a BLK x BLK block, issues two-tap reference
// reads and produces interpolated angular predictions.   rev 1.0
// ============================================================================
module angle_pred_sequencer #(
  parameter int BLK    = 8,
  parameter int DATA_W = 8,
  parameter int REF_AW = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en1,
  input  logic                    en2,
  input  logic [4:0]              angle,
  output logic [REF_AW-1:0]       ref_addr0,
  output logic [REF_AW-1:0]       ref_addr1,
  input  logic [DATA_W-1:0]       ref_data0,
  input  logic [DATA_W-1:0]       ref_data1,
  output logic                    pred_valid,
  output logic [DATA_W-1:0]       pred_data,
  output logic [$clog2(BLK)-1:0]  pred_x,
  output logic [$clog2(BLK)-1:0]  pred_y,
  output logic                    restart,
  output logic                    busy
);

  localparam int XW = $clog2(BLK);
  localparam int PW = XW + 5;
  localparam int MW = DATA_W + 7;
  localparam logic [XW-1:0] MAXC = XW'(BLK - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          angle_q, angle_d;
  logic [XW-1:0]       ix_q, ix_d, iy_q, iy_d, cx_q, cx_d, cy_q, cy_d;
  logic [REF_AW-1:0]   addr0_q, addr0_d, addr1_q, addr1_d;
  logic                hold_q, hold_d, drain_q, drain_d;
  logic [DATA_W-1:0]   hold0_q, hold0_d, hold1_q, hold1_d;
  logic                pv_q, pv_d, restart_q, restart_d, busy_q, busy_d;
  logic [DATA_W-1:0]   pdata_q, pdata_d;
  logic [XW-1:0]       px_q, px_d, py_q, py_d;

  logic [XW-1:0]       nx, ny;
  logic                last_issue, do_issue, do_compute, do_capture;
  logic [DATA_W-1:0]   d0, d1;
  logic [4:0]          frac;
  logic [MW-1:0]       sum;

  function automatic logic [PW-1:0] pos_of(input logic [XW-1:0] y, input logic [4:0] ang);
    return (PW'(y) + PW'(1)) * PW'(ang);
  endfunction

  function automatic logic [REF_AW-1:0] addr_of(input logic [XW-1:0] x,
                                                input logic [XW-1:0] y,
                                                input logic [4:0]    ang);
    logic [PW-1:0] pos;
    pos = pos_of(y, ang);
    return REF_AW'(x) + REF_AW'(pos[PW-1:5]) + REF_AW'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    angle_d    = angle_q;
    ix_d       = ix_q;
    iy_d       = iy_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    hold_d     = hold_q;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    drain_d    = drain_q;
    pv_d       = 1'b0;
    pdata_d    = pdata_q;
    px_d       = px_q;
    py_d       = py_q;
    restart_d  = 1'b0;
    do_issue   = 1'b0;
    do_compute = 1'b0;
    do_capture = 1'b0;

    nx         = (ix_q == MAXC) ? '0 : ix_q + XW'(1);
    ny         = (ix_q == MAXC) ? iy_q + XW'(1) : iy_q;
    last_issue = (nx == MAXC) && (ny == MAXC);

    // During a stall the RAM keeps reading the held address, so the data
    // belonging to the pending position is parked in the hold registers.
    d0   = hold_q ? hold0_q : ref_data0;
    d1   = hold_q ? hold1_q : ref_data1;
    frac = pos_of(cy_q, angle_q)[4:0];
    sum  = MW'(6'd32 - {1'b0, frac}) * MW'(d0) + MW'(frac) * MW'(d1) + MW'(16);

    case (state_q)
      S_IDLE: if (en1) begin
        state_d = S_PRIME;
        angle_d = angle;
        ix_d    = '0;
        iy_d    = '0;
        cx_d    = '0;
        cy_d    = '0;
        drain_d = 1'b0;
        addr0_d = addr_of('0, '0, angle);
        addr1_d = addr0_d + REF_AW'(1);
      end
      S_PRIME: if (!en1) state_d = S_IDLE;
               else begin
                 do_issue = 1'b1;
                 state_d  = S_RUN;
               end
      S_RUN: if (!en1) state_d = S_IDLE;
             else if (en2) begin
               do_issue   = 1'b1;
               do_compute = 1'b1;
               if (last_issue) state_d = S_DRAIN;
             end else do_capture = 1'b1;
      S_DRAIN: if (!en1) state_d = S_IDLE;
               else if (en2) begin
                 do_compute = 1'b1;
                 drain_d    = 1'b1;
                 if (drain_q) state_d = S_DONE;
               end else do_capture = 1'b1;
      S_DONE: if (!en1) state_d = S_IDLE;
              else restart_d = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (do_issue) begin
      ix_d    = nx;
      iy_d    = ny;
      addr0_d = addr_of(nx, ny, angle_q);
      addr1_d = addr0_d + REF_AW'(1);
    end
    if (do_compute) begin
      pv_d    = 1'b1;
      pdata_d = DATA_W'(sum >> 5);
      px_d    = cx_q;
      py_d    = cy_q;
      cx_d    = (cx_q == MAXC) ? '0 : cx_q + XW'(1);
      cy_d    = (cx_q == MAXC) ? cy_q + XW'(1) : cy_q;
      hold_d  = 1'b0;
    end
    if (do_capture && !hold_q) begin
      hold_d  = 1'b1;
      hold0_d = ref_data0;
      hold1_d = ref_data1;
    end
    if (state_d == S_IDLE) hold_d = 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      angle_q   <= '0;
      ix_q      <= '0;
      iy_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      hold_q    <= 1'b0;
      hold0_q   <= '0;
      hold1_q   <= '0;
      drain_q   <= 1'b0;
      pv_q      <= 1'b0;
      pdata_q   <= '0;
      px_q      <= '0;
      py_q      <= '0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      ix_q      <= ix_d;
      iy_q      <= iy_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      hold_q    <= hold_d;
      hold0_q   <= hold0_d;
      hold1_q   <= hold1_d;
      drain_q   <= drain_d;
      pv_q      <= pv_d;
      pdata_q   <= pdata_d;
      px_q      <= px_d;
      py_q      <= py_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
    end
  end

  assign ref_addr0  = addr0_q;
  assign ref_addr1  = addr1_q;
  assign pred_valid = pv_q;
  assign pred_data  = pdata_q;
  assign pred_x     = px_q;
  assign pred_y     = py_q;
  assign restart    = restart_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
